exec_control: RTL and testbench

EXEC_CONTROL -- requirements
Module: exec_control

---
 rtl/exec_control_pkg.sv | 50 +++++
 rtl/exec_control_alu_4bit.sv | 43 ++++
 rtl/exec_control.sv | 131 +++++++++++++
 tb/tb_exec_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_control_pkg.sv
// Shared definitions for the exec_control sequencer: opcodes, FSM states, ALU ops.
package exec_control_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LIT = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_CMP = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_PGH = 4'hA;
  localparam logic [3:0] OP_PGL = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NOT  = 3'd6
  } alu_op_e;

  // CMP shares the subtractor; opcodes without an ALU result map to PASS.
  function automatic alu_op_e alu_op_for(input logic [3:0] opcode);
    case (opcode)
      OP_ADD:         return ALU_ADD;
      OP_SUB, OP_CMP: return ALU_SUB;
      OP_AND:         return ALU_AND;
      OP_OR:          return ALU_OR;
      OP_XOR:         return ALU_XOR;
      OP_NOT:         return ALU_NOT;
      default:        return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/exec_control_alu_4bit.sv
// Purely combinational 4-bit ALU. Carry is the adder carry-out for ADD and
// the "no borrow" indication (acc >= operand) for SUB.
module alu_4bit
  import exec_control_pkg::*;
(
  input  logic [3:0] acc_i,
  input  logic [3:0] operand_i,
  input  alu_op_e    op_i,
  output logic [3:0] result_o,
  output logic       carry_o,
  output logic       zero_o
);

  logic [4:0] sum;
  logic [4:0] diff;

  assign sum  = {1'b0, acc_i} + {1'b0, operand_i};
  assign diff = {1'b0, acc_i} - {1'b0, operand_i};

  // Select the result and carry for the requested operation.
  always_comb begin
    result_o = operand_i;
    carry_o  = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o = sum[3:0];
        carry_o  = sum[4];
      end
      ALU_SUB: begin
        result_o = diff[3:0];
        carry_o  = ~diff[4];
      end
      ALU_AND: result_o = acc_i & operand_i;
      ALU_OR:  result_o = acc_i | operand_i;
      ALU_XOR: result_o = acc_i ^ operand_i;
      ALU_NOT: result_o = ~acc_i;
      default: result_o = operand_i;
    endcase
  end

  assign zero_o = (result_o == 4'h0);

endmodule

// File: rtl/exec_control.sv
// Two-phase FETCH/EXECUTE sequencer with accumulator, flags, jump page and
// output port. Upstream strobes are combinational from the registered state
// so that reset and enable can gate them within the same cycle.
module exec_control
  import exec_control_pkg::*;
#(
  parameter logic [7:0] RESET_PAGE = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  instruction,
  input  logic [3:0]  operand,
  output logic        enablec,
  output logic        enablef,
  output logic        load,
  output logic [11:0] load_data,
  output logic [3:0]  accu,
  output logic        flag_c,
  output logic        flag_z,
  output logic [3:0]  out_data,
  output logic        out_valid,
  output logic        phase,
  output logic        halted
);

  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;
  logic [7:0] page_q, page_d;
  logic [3:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;

  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       run;
  logic       jump_take;

  alu_4bit u_alu (
    .acc_i    (acc_q),
    .operand_i(operand),
    .op_i     (alu_op_for(instruction)),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero)
  );

  // Strobes only when out of reset and enabled; jumps test pre-instruction flags.
  assign run       = reset & enable;
  assign jump_take = (instruction == OP_JMP) |
                     ((instruction == OP_JC) & flag_c_q) |
                     ((instruction == OP_JZ) & flag_z_q);
  assign enablef   = run & (state_q == ST_FETCH);
  assign enablec   = run & (state_q == ST_FETCH);
  assign load      = run & (state_q == ST_EXECUTE) & jump_take;
  assign load_data = {page_q, operand};

  assign accu      = acc_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign phase     = (state_q == ST_EXECUTE);
  assign halted    = (state_q == ST_HALT);

  // Next-state and instruction commit; everything holds when enable is low.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    page_d      = page_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (enable) begin
      case (state_q)
        ST_FETCH: state_d = ST_EXECUTE;
        ST_EXECUTE: begin
          state_d = (instruction == OP_HLT) ? ST_HALT : ST_FETCH;
          case (instruction)
            OP_LIT, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
              acc_d    = alu_result;
              flag_z_d = alu_zero;
            end
            OP_ADD, OP_SUB: begin
              acc_d    = alu_result;
              flag_z_d = alu_zero;
              flag_c_d = alu_carry;
            end
            OP_CMP: begin
              flag_z_d = alu_zero;
              flag_c_d = alu_carry;
            end
            OP_PGH: page_d[7:4] = operand;
            OP_PGL: page_d[3:0] = operand;
            OP_OUT: begin
              out_data_d  = acc_q;
              out_valid_d = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      acc_q       <= 4'h0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      page_q      <= RESET_PAGE;
      out_data_q  <= 4'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      page_q      <= page_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_exec_control.sv
// Bench for exec_control: per-cycle comparison against a behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_exec_control;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  instruction;
  logic [3:0]  operand;
  logic        enablec, enablef, load;
  logic [11:0] load_data;
  logic [3:0]  accu;
  logic        flag_c, flag_z;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        phase, halted;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: 0 = fetch, 1 = execute, 2 = halted.
  int m_phase, m_acc, m_c, m_z, m_page, m_out, m_ov;

  logic        last_load;
  logic [11:0] last_ld;

  // Clock block
  always #5 clock = ~clock;

  exec_control #(.RESET_PAGE(8'h00)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .instruction(instruction),
    .operand    (operand),
    .enablec    (enablec),
    .enablef    (enablef),
    .load       (load),
    .load_data  (load_data),
    .accu       (accu),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .phase      (phase),
    .halted     (halted)
  );

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic compare_all();
    bit run, jump, exp_f, exp_load;
    int ins, opd;
    ins  = int'(instruction);
    opd  = int'(operand);
    run  = (reset === 1'b1) && (enable === 1'b1);
    jump = (ins == 9) || (ins == 12 && m_c == 1) || (ins == 13 && m_z == 1);
    exp_f    = run && (m_phase == 0);
    exp_load = run && (m_phase == 1) && jump;
    chk("enablef",   12'(enablef),   12'(exp_f));
    chk("enablec",   12'(enablec),   12'(exp_f));
    chk("load",      12'(load),      12'(exp_load));
    chk("load_data", load_data,      12'(m_page * 16 + opd));
    chk("accu",      12'(accu),      12'(m_acc));
    chk("flag_c",    12'(flag_c),    12'(m_c));
    chk("flag_z",    12'(flag_z),    12'(m_z));
    chk("out_data",  12'(out_data),  12'(m_out));
    chk("out_valid", 12'(out_valid), 12'(m_ov));
    chk("phase",     12'(phase),     12'(m_phase == 1));
    chk("halted",    12'(halted),    12'(m_phase == 2));
    last_load = load;
    last_ld   = load_data;
  endtask

  // Advance the model by one rising edge using the applied inputs.
  task automatic model_step();
    int ins, opd;
    ins = int'(instruction);
    opd = int'(operand);
    if (reset == 1'b0) begin
      m_phase = 0; m_acc = 0; m_c = 0; m_z = 0; m_page = 0; m_out = 0; m_ov = 0;
    end else if (enable == 1'b0) begin
      m_ov = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
      m_ov    = 0;
    end else if (m_phase == 1) begin
      m_ov = (ins == 14) ? 1 : 0;
      case (ins)
        1: begin m_acc = opd; m_z = (m_acc == 0); end
        2: begin
          m_c   = (m_acc + opd > 15);
          m_acc = (m_acc + opd) % 16;
          m_z   = (m_acc == 0);
        end
        3: begin
          m_c   = (m_acc >= opd);
          m_acc = (m_acc - opd + 16) % 16;
          m_z   = (m_acc == 0);
        end
        4: begin m_acc = m_acc & opd; m_z = (m_acc == 0); end
        5: begin m_acc = m_acc | opd; m_z = (m_acc == 0); end
        6: begin m_acc = m_acc ^ opd; m_z = (m_acc == 0); end
        7: begin m_acc = 15 - m_acc;  m_z = (m_acc == 0); end
        8: begin m_c = (m_acc >= opd); m_z = (m_acc == opd); end
        10: m_page = opd * 16 + (m_page % 16);
        11: m_page = (m_page / 16) * 16 + opd;
        14: m_out = m_acc;
        default: ;
      endcase
      m_phase = (ins == 15) ? 2 : 0;
    end else begin
      m_ov = 0;
    end
  endtask

  // Driver: one full clock cycle with the given inputs.
  task automatic cyc(input logic r, input logic e, input logic [3:0] i, input logic [3:0] o);
    @(negedge clock);
    reset = r; enable = e; instruction = i; operand = o;
    #1 compare_all();
    @(posedge clock);
    model_step();
    #1;
  endtask

  // One instruction: fetch cycle then execute cycle.
  task automatic step(input logic [3:0] i, input logic [3:0] o);
    cyc(1'b1, 1'b1, i, o);
    cyc(1'b1, 1'b1, i, o);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; instruction = 4'h0; operand = 4'h0;
    m_phase = 0; m_acc = 0; m_c = 0; m_z = 0; m_page = 0; m_out = 0; m_ov = 0;
    @(posedge clock);
    cyc(1'b0, 1'b0, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 4'h0, 4'h0);
    chk("reset_accu",   12'(accu),   12'h0);
    chk("reset_halted", 12'(halted), 12'h0);

    // LIT 5
    step(4'h1, 4'h5);
    chk("lit5_accu", 12'(accu),   12'h5);
    chk("lit5_z",    12'(flag_z), 12'h0);

    // LIT F, ADD 1 wraps to zero with carry
    step(4'h1, 4'hF);
    step(4'h2, 4'h1);
    chk("add_wrap_accu", 12'(accu),   12'h0);
    chk("add_wrap_c",    12'(flag_c), 12'h1);
    chk("add_wrap_z",    12'(flag_z), 12'h1);
    step(4'h3, 4'h1);
    chk("sub_borrow_accu", 12'(accu),   12'hF);
    chk("sub_borrow_c",    12'(flag_c), 12'h0);

    // Page set then jump
    step(4'hA, 4'h1);
    step(4'hB, 4'h2);
    step(4'h9, 4'h3);
    chk("jmp_load",      12'(last_load), 12'h1);
    chk("jmp_load_data", last_ld,        12'h123);

    // CMP equal then JZ taken; CMP below then JC not taken
    step(4'h1, 4'h5);
    step(4'h8, 4'h5);
    step(4'hD, 4'h7);
    chk("jz_load",     12'(last_load),   12'h1);
    chk("jz_ld_low",   12'(last_ld[3:0]), 12'h7);
    chk("cmp_accu",    12'(accu),        12'h5);
    step(4'h8, 4'h6);
    step(4'hC, 4'h7);
    chk("jc_not_taken", 12'(last_load), 12'h0);

    // OUT pulse
    step(4'h1, 4'hA);
    step(4'hE, 4'h0);
    chk("out_data",  12'(out_data),  12'hA);
    chk("out_pulse", 12'(out_valid), 12'h1);
    cyc(1'b1, 1'b1, 4'h0, 4'h0);
    chk("out_pulse_end", 12'(out_valid), 12'h0);
    cyc(1'b1, 1'b1, 4'h0, 4'h0);

    // Reset mid-EXECUTE of ADD
    step(4'h1, 4'h7);
    cyc(1'b1, 1'b1, 4'h2, 4'h3);
    cyc(1'b0, 1'b1, 4'h2, 4'h3);
    chk("rst_exec_accu",  12'(accu),  12'h0);
    chk("rst_exec_phase", 12'(phase), 12'h0);
    cyc(1'b0, 1'b1, 4'h2, 4'h3);
    step(4'h1, 4'h9);
    chk("resume_accu", 12'(accu), 12'h9);

    // HALT with enable toggling, then reset out of it
    step(4'hF, 4'h0);
    chk("halt_entered", 12'(halted), 12'h1);
    for (int k = 0; k < 10; k++)
      cyc(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    chk("halt_held", 12'(halted), 12'h1);
    chk("halt_accu", 12'(accu),   12'h9);
    cyc(1'b0, 1'b1, 4'h0, 4'h0);
    chk("halt_reset", 12'(halted), 12'h0);
    step(4'h1, 4'h3);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      logic r, e;
      r = (m_phase == 2) ? 1'($urandom_range(0, 5) != 0) : 1'($urandom_range(0, 60) != 0);
      e = 1'($urandom_range(0, 7) != 0);
      cyc(r, e, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
